ft6206_i2c_responder: RTL
=========================

// Module: ft6206_i2c_responder
// PURPOSE
//  I2C target emulating the FT6206 capacitive-touch controller: the other end of the ft6206_controller I2C initiator.
//  Decodes START/STOP/address/pointer/data from oversampled SCL/SDA, serves a register map built from touch inputs,
//  drives SDA open-drain. Used as the touch model in SIMULATION and for loopback tests against ft6206_controller on FPGA.
// PARAMETERS
//  I2C_ADDR     7'h38  7-bit target address responded to
//  SYNC_STAGES  2      synchronizer flops on scl_i/sda_i (>=2)
//  CHIP_ID      8'h06  value returned at register 0xA3
//  VENDOR_ID    8'h11  value returned at register 0xA8
// PORTS
//  clk        in   1   system clock; must be >= 20x SCL frequency
//  rst        in   1   reset, synchronous, active-high
//  scl_i      in   1   I2C clock from bus (asynchronous)
//  sda_i      in   1   I2C data from bus (asynchronous)
//  sda_oe     out  1   1 = pull SDA low; 0 = release (open-drain)
//  p1_valid   in   1   touch point 1 present
//  p1_x/p1_y  in   12  touch point 1 coordinates
//  p2_valid   in   1   touch point 2 present
//  p2_x/p2_y  in   12  touch point 2 coordinates
//  int_n      out  1   low while p1_valid|p2_valid (polling mode), registered
//  busy       out  1   high from START until STOP or address mismatch
//  threshold  out  8   register 0x80 contents (R/W)
// BEHAVIOUR
//  Reset: sda_oe=0, int_n=1, busy=0, threshold=8'h80, pointer=0, state IDLE. rst mid-transfer aborts immediately, SDA released.
//  Sampling: scl/sda pass SYNC_STAGES flops plus one edge-detect flop. START = SDA 1->0 while SCL=1; STOP = SDA 0->1 while SCL=1.
//  Data bits sampled on synchronized SCL rise; sda_oe changes only on the clk cycle after synchronized SCL fall.
//  START (incl. repeated) in any state -> ADDR, bit counter cleared, touch inputs snapshot into shadow regs (coherent multi-byte reads).
//  STOP in any state -> IDLE, sda_oe=0, busy=0. Pointer is retained across transactions.
//  States:
//   IDLE     wait START.
//   ADDR     shift 8 bits MSB first; addr!=I2C_ADDR -> IGNORE (no ACK); else ADDR_ACK.
//   ADDR_ACK drive ACK 9th clock; R/W=0 -> PTR, R/W=1 -> RD_DATA with byte=reg[pointer].
//   PTR      shift 8 bits -> pointer; PTR_ACK (ACK) -> WR_DATA.
//   WR_DATA  shift 8 bits; write reg[pointer] if writable (0x00 DEV_MODE, 0x80), else discard; always ACK (WR_ACK); pointer++.
//   RD_DATA  drive byte MSB first (sda_oe = ~bit); release on SCL fall after bit0 -> RD_ACK.
//   RD_ACK   sample master bit on SCL rise: 0 (ACK) -> pointer++, load reg[pointer+1], RD_DATA; 1 (NACK) -> IGNORE.
//   IGNORE   sda_oe=0, wait START/STOP.
//  Pointer is 8 bits, wraps 0xFF->0x00. Increment happens once per byte, on ACK completion.
//  Register map (reads, from snapshot): 0x00 DEV_MODE (R/W, reset 0); 0x02 = p1_valid+p2_valid (0..2);
//   0x03 {ev,2'b00,x[11:8]} ev=2'b10 contact if valid else 2'b01 lift-up; 0x04 x[7:0]; 0x05 {4'h0,y[11:8]}; 0x06 y[7:0] (P1);
//   0x09..0x0C same layout for P2 with id nibble 4'h1 in 0x0B[7:4]; 0x80 threshold; 0xA3 CHIP_ID; 0xA8 VENDOR_ID; all else 0x00.
//  Invalid point: 0x03/0x09 event = lift-up, coordinates still reflect inputs. int_n has 1-cycle latency from valid inputs.
//  Simultaneous START and STOP detection is impossible (one SDA edge per cycle); START priority over state logic.
//  SDA never driven while SCL synchronized high except to hold a value set during low phase.
// TESTING
//  1 Write 0x70 (addr 0x38 W), ptr 0x02, Sr, 0x71, read 5 bytes NACK last; p1=(x=0x0F0,y=0x140) valid, p2 invalid
//    -> bytes 0x01,0x80,0xF0,0x01,0x40; all ACKs low; sda_oe=0 after STOP.
//  2 Address 0x52 W -> no ACK (SDA high 9th clock), busy drops, sda_oe stays 0 until next START.
//  3 Write ptr 0x80, data 0x2A; then read 0x80 -> 0x2A, threshold=0x2A; write 0x55 to 0x04 -> ACKed, 0x04 unchanged.
//  4 Ptr 0xFF, read 2 bytes -> 0x00 then reg 0x00 (wrap), pointer ends at 0x00.
//  5 Change p1_x mid-read of 0x03..0x06 -> all bytes match START-time snapshot; next transaction sees new value.
//  6 Assert rst during RD_DATA with sda_oe=1 -> sda_oe=0 next cycle, int_n=1, threshold=0x80, read 0xA3 -> 0x06.

Source files
------------

// File: rtl/ft6206_i2c_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ft6206_i2c_responder                                             |
// | Brief   : I2C target modelling the FT6206 touch controller register map.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ft6206_i2c_responder #(
  parameter logic [6:0] I2C_ADDR    = 7'h38,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CHIP_ID     = 8'h06,
  parameter logic [7:0] VENDOR_ID   = 8'h11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic        p1_valid,
  input  logic [11:0] p1_x,
  input  logic [11:0] p1_y,
  input  logic        p2_valid,
  input  logic [11:0] p2_x,
  input  logic [11:0] p2_y,
  output logic        int_n,
  output logic        busy,
  output logic [7:0]  threshold
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic r_scl_d, r_sda_d;
  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
      r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  // Touch snapshot taken at every START so a multi-byte read is coherent
  logic        r_s1_v, r_s2_v;
  logic [11:0] r_s1_x, r_s1_y, r_s2_x, r_s2_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v <= 1'b0; r_s1_x <= '0; r_s1_y <= '0;
      r_s2_v <= 1'b0; r_s2_x <= '0; r_s2_y <= '0;
    end else if (w_start) begin
      r_s1_v <= p1_valid; r_s1_x <= p1_x; r_s1_y <= p1_y;
      r_s2_v <= p2_valid; r_s2_x <= p2_x; r_s2_y <= p2_y;
    end
  end

  state_t     r_state, w_state_nxt;
  logic [3:0] r_bit_cnt, w_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt, r_ptr, w_ptr_nxt;
  logic [7:0] r_dev_mode, w_dev_nxt, r_threshold, w_thr_nxt;
  logic       r_sda_oe, w_oe_nxt, r_busy, w_busy_nxt, r_int_n;
  logic [7:0] w_rd_cur, w_rd_next;

  function automatic logic [1:0] event_code(input logic valid);
    return valid ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [7:0] reg_read(input logic [7:0] addr);
    case (addr)
      8'h00:   reg_read = r_dev_mode;
      8'h02:   reg_read = 8'(r_s1_v) + 8'(r_s2_v);
      8'h03:   reg_read = {event_code(r_s1_v), 2'b00, r_s1_x[11:8]};
      8'h04:   reg_read = r_s1_x[7:0];
      8'h05:   reg_read = {4'h0, r_s1_y[11:8]};
      8'h06:   reg_read = r_s1_y[7:0];
      8'h09:   reg_read = {event_code(r_s2_v), 2'b00, r_s2_x[11:8]};
      8'h0A:   reg_read = r_s2_x[7:0];
      8'h0B:   reg_read = {4'h1, r_s2_y[11:8]};
      8'h0C:   reg_read = r_s2_y[7:0];
      8'h80:   reg_read = r_threshold;
      8'hA3:   reg_read = CHIP_ID;
      8'hA8:   reg_read = VENDOR_ID;
      default: reg_read = 8'h00;
    endcase
  endfunction

  assign w_rd_cur  = reg_read(r_ptr);
  assign w_rd_next = reg_read(r_ptr + 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_dev_mode  <= '0;
      r_threshold <= 8'h80;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_int_n     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_ptr       <= w_ptr_nxt;
      r_dev_mode  <= w_dev_nxt;
      r_threshold <= w_thr_nxt;
      r_sda_oe    <= w_oe_nxt;
      r_busy      <= w_busy_nxt;
      r_int_n     <= ~(p1_valid | p2_valid);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_ptr_nxt   = r_ptr;
    w_dev_nxt   = r_dev_mode;
    w_thr_nxt   = r_threshold;
    w_oe_nxt    = r_sda_oe;
    w_busy_nxt  = r_busy;
    if (w_start) begin
      w_state_nxt = ST_ADDR;
      w_cnt_nxt   = '0;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b1;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WR_DATA: begin
          if (w_scl_rise && r_bit_cnt != 4'd8) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_cnt_nxt   = r_bit_cnt + 4'd1;
          end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_cnt_nxt = '0;
            w_oe_nxt  = 1'b1;
            if (r_state == ST_ADDR) begin
              if (r_shift[7:1] == I2C_ADDR) begin
                w_state_nxt = ST_ADDR_ACK;
              end else begin
                w_state_nxt = ST_IGNORE;
                w_oe_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
              end
            end else if (r_state == ST_PTR) begin
              w_ptr_nxt   = r_shift;
              w_state_nxt = ST_PTR_ACK;
            end else begin
              if (r_ptr == 8'h00) w_dev_nxt = r_shift;
              if (r_ptr == 8'h80) w_thr_nxt = r_shift;
              w_state_nxt = ST_WR_ACK;
            end
          end
        end
        // ACK is held through one full SCL pulse: count its rise, leave on its fall
        ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
          if (w_scl_rise) begin
            w_cnt_nxt = 4'd1;
          end else if (w_scl_fall && r_bit_cnt == 4'd1) begin
            w_cnt_nxt   = '0;
            w_oe_nxt    = 1'b0;
            w_state_nxt = ST_WR_DATA;
            if (r_state == ST_WR_ACK) w_ptr_nxt = r_ptr + 8'd1;
            if (r_state == ST_ADDR_ACK) begin
              if (r_shift[0]) begin
                w_state_nxt = ST_RD_DATA;
                w_oe_nxt    = ~w_rd_cur[7];
                w_shift_nxt = {w_rd_cur[6:0], 1'b0};
              end else begin
                w_state_nxt = ST_PTR;
              end
            end
          end
        end
        ST_RD_DATA: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_oe_nxt    = 1'b0;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_RD_ACK;
            end else begin
              w_oe_nxt    = ~r_shift[7];
              w_shift_nxt = {r_shift[6:0], 1'b0};
            end
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_ptr_nxt   = r_ptr + 8'd1;
              w_shift_nxt = w_rd_next;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_RD_DATA;
            end else begin
              w_state_nxt = ST_IGNORE;
            end
          end
        end
        default: w_oe_nxt = 1'b0;
      endcase
    end
  end

  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign int_n     = r_int_n;
  assign threshold = r_threshold;

endmodule
`default_nettype wire
